io_hexdisplay: RTL and testbench

Parametrised 7-segment status display peripheral for the j1 I/O bus. It generalises the fixed 16-bit / 4-digit status register into DIGITS hex digits with per-digit blanking, decimal points, blinking, leading-zero suppression and register readback. It drives both static (one segment bus per digit) and time-multiplexed (shared segment bus plus anode select) outputs. It sits between the CPU I/O port and the board display pins.

---
 rtl/io_hexdisplay.sv | 197 +++++++++++++++++++
 tb/tb_io_hexdisplay.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/io_hexdisplay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_hexdisplay                                                              |
// | Memory-mapped DIGITS-wide 7-segment hex display for the j1 I/O bus with    |
// | blanking, decimal points, blinking, leading-zero suppression and scan out. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module io_hexdisplay #(
  parameter int                  DIGITS      = 4,
  parameter logic [15:0]         BASE        = 16'h1000,
  parameter logic [DIGITS*4-1:0] RESET_VALUE = {DIGITS{4'h8}},
  parameter int                  BLINK_DIV   = 24,
  parameter int                  SCAN_DIV    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           io_addr,
  input  logic [15:0]           io_din,
  input  logic                  io_wr,
  input  logic                  io_rd,
  output logic [15:0]           io_dout,
  output logic [7*DIGITS-1:0]   seg_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [6:0]            scan_seg,
  output logic                  scan_dp,
  output logic [DIGITS-1:0]     scan_an
);

  localparam int          c_WORDS   = DIGITS / 4;
  localparam int          c_IDX_W   = $clog2(DIGITS);
  localparam logic [15:0] c_MASK    = 16'((32'd1 << DIGITS) - 32'd1);
  localparam logic [15:0] c_A_BLANK = BASE + 16'd16;
  localparam logic [15:0] c_A_DP    = BASE + 16'd17;
  localparam logic [15:0] c_A_BLINK = BASE + 16'd18;
  localparam logic [15:0] c_A_CTRL  = BASE + 16'd19;

  logic [15:0]          r_data [c_WORDS];
  logic [15:0]          r_blank;
  logic [15:0]          r_dp;
  logic [15:0]          r_blink;
  logic [1:0]           r_ctrl;
  logic [15:0]          r_dout;
  logic [BLINK_DIV-1:0] r_blink_cnt;
  logic [SCAN_DIV-1:0]  r_scan_cnt;
  logic [c_IDX_W-1:0]   r_scan_idx;
  logic [7*DIGITS-1:0]  r_seg;
  logic [DIGITS-1:0]    r_dpn;
  logic [6:0]           r_scan_seg;
  logic                 r_scan_dp;
  logic [DIGITS-1:0]    r_scan_an;

  logic [3:0]           w_digit [DIGITS];
  logic [DIGITS-1:0]    w_lz;
  logic                 w_run;
  logic [DIGITS-1:0]    w_dark;
  logic [7*DIGITS-1:0]  w_seg;
  logic [DIGITS-1:0]    w_dpn;
  logic [6:0]           w_scan_seg;
  logic                 w_scan_dp;
  logic [DIGITS-1:0]    w_scan_an;
  logic [15:0]          w_rdata;
  logic                 w_phase;

  function automatic logic [6:0] f_hex(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0010000;
      4'hA: p = 7'b0001000;
      4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110;
      4'hD: p = 7'b0100001;
      4'hE: p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  assign w_phase = r_blink_cnt[BLINK_DIV-1];

  // A digit is suppressed when it and every more-significant digit are zero.
  always_comb begin
    w_lz  = '0;
    w_run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_run   = w_run & (w_digit[k] == 4'h0);
      w_lz[k] = w_run & (k != 0);
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign w_digit[k] = r_data[k/4][(k%4)*4 +: 4];
    assign w_dark[k]  = r_blank[k]
                      | (r_ctrl[0] & r_blink[k] & w_phase)
                      | (r_ctrl[1] & w_lz[k]);
    assign w_seg[k*7 +: 7] = w_dark[k] ? 7'h7F : f_hex(w_digit[k]);
    assign w_dpn[k]        = ~(r_dp[k] & ~w_dark[k]);
  end

  always_comb begin
    w_scan_seg = 7'h7F;
    w_scan_dp  = 1'b1;
    w_scan_an  = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_scan_idx == c_IDX_W'(k)) begin
        w_scan_seg   = w_seg[k*7 +: 7];
        w_scan_dp    = w_dpn[k];
        w_scan_an[k] = 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = 16'h0000;
    for (int i = 0; i < c_WORDS; i++) begin
      if (io_addr == BASE + 16'(i)) w_rdata = r_data[i];
    end
    if (io_addr == c_A_BLANK) w_rdata = r_blank;
    if (io_addr == c_A_DP)    w_rdata = r_dp;
    if (io_addr == c_A_BLINK) w_rdata = r_blink;
    if (io_addr == c_A_CTRL)  w_rdata = {14'h0000, r_ctrl};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_WORDS; i++) r_data[i] <= RESET_VALUE[i*16 +: 16];
      r_blank <= 16'h0000;
      r_dp    <= 16'h0000;
      r_blink <= 16'h0000;
      r_ctrl  <= 2'b00;
    end else if (io_wr) begin
      for (int i = 0; i < c_WORDS; i++) begin
        if (io_addr == BASE + 16'(i)) r_data[i] <= io_din;
      end
      if (io_addr == c_A_BLANK) r_blank <= io_din & c_MASK;
      if (io_addr == c_A_DP)    r_dp    <= io_din & c_MASK;
      if (io_addr == c_A_BLINK) r_blink <= io_din & c_MASK;
      if (io_addr == c_A_CTRL)  r_ctrl  <= io_din[1:0];
    end
  end

  // Read mux samples pre-write state, so a colliding read returns the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= 16'h0000;
    end else if (io_rd) begin
      r_dout <= w_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_scan_cnt  <= '0;
      r_scan_idx  <= '0;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_DIV'(1);
      r_scan_cnt  <= r_scan_cnt + SCAN_DIV'(1);
      if (&r_scan_cnt) begin
        r_scan_idx <= (r_scan_idx == c_IDX_W'(DIGITS - 1)) ? '0 : r_scan_idx + c_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg      <= '1;
      r_dpn      <= '1;
      r_scan_seg <= 7'h7F;
      r_scan_dp  <= 1'b1;
      r_scan_an  <= '1;
    end else begin
      r_seg      <= w_seg;
      r_dpn      <= w_dpn;
      r_scan_seg <= w_scan_seg;
      r_scan_dp  <= w_scan_dp;
      r_scan_an  <= w_scan_an;
    end
  end

  assign io_dout  = r_dout;
  assign seg_out  = r_seg;
  assign dp_out   = r_dpn;
  assign scan_seg = r_scan_seg;
  assign scan_dp  = r_scan_dp;
  assign scan_an  = r_scan_an;

endmodule
`default_nettype wire

// File: tb/tb_io_hexdisplay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_io_hexdisplay                                                           |
// | Directed bench: a 4-digit instance (fast blink/scan) and an 8-digit one.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_io_hexdisplay;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] io_addr = 16'h0000;
  logic [15:0] io_din  = 16'h0000;
  logic        io_wr   = 1'b0;
  logic        io_rd   = 1'b0;

  logic [15:0] dout_a, dout_b;
  logic [27:0] seg_a;
  logic [55:0] seg_b;
  logic [3:0]  dp_a, an_a;
  logic [7:0]  dp_b, an_b;
  logic [6:0]  sseg_a, sseg_b;
  logic        sdp_a, sdp_b;

  int checks = 0;
  int errors = 0;
  logic [6:0] pat [4];

  always #5 clk = ~clk;

  io_hexdisplay #(.DIGITS(4), .BLINK_DIV(4), .SCAN_DIV(2)) u_dut_a (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_din(io_din),
    .io_wr(io_wr), .io_rd(io_rd), .io_dout(dout_a), .seg_out(seg_a),
    .dp_out(dp_a), .scan_seg(sseg_a), .scan_dp(sdp_a), .scan_an(an_a)
  );

  io_hexdisplay #(.DIGITS(8)) u_dut_b (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_din(io_din),
    .io_wr(io_wr), .io_rd(io_rd), .io_dout(dout_b), .seg_out(seg_b),
    .dp_out(dp_b), .scan_seg(sseg_b), .scan_dp(sdp_b), .scan_an(an_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    io_addr = a; io_din = d; io_wr = 1'b1;
    tick();
    io_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    io_addr = a; io_rd = 1'b1;
    tick();
    io_rd = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       dark;
    int         idx;
    logic [3:0] exp_an;
    pat[0] = 7'b0001110;
    pat[1] = 7'b0001000;
    pat[2] = 7'b0100100;
    pat[3] = 7'b1111001;

    tick(); tick();
    check("rst_seg", seg_a, {28{1'b1}});
    check("rst_an", an_a, 4'hF);
    check("rst_sseg", sseg_a, 7'h7F);
    check("rst_dout", dout_a, 16'h0000);
    reset = 1'b0;
    tick();
    check("first_seg_a", seg_a, 28'h0);
    check("first_dp_a", dp_a, 4'hF);
    check("first_seg_b", seg_b, 56'h0);
    for (int i = 16; i < 20; i++) begin
      rd(16'h1000 + 16'(i));
      check("rst_reg", dout_a, 16'h0000);
    end
    rd(16'h1000);
    check("rst_data_a", dout_a, 16'h8888);
    check("rst_data_b", dout_b, 16'h8888);

    wr(16'h1000, 16'h12AF);
    tick();
    check("wr_seg", seg_a, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});
    rd(16'h1000);
    check("rd_data0", dout_a, 16'h12AF);
    io_addr = 16'h1010;
    tick(); tick();
    check("rd_hold", dout_a, 16'h12AF);

    wr(16'h1010, 16'h0002);
    tick();
    check("blank_seg", seg_a, {7'b1111001, 7'b0100100, 7'h7F, 7'b0001110});
    wr(16'h1010, 16'h0000);

    wr(16'h1011, 16'h0005);
    io_addr = 16'h1011; io_din = 16'h000A; io_rd = 1'b1; io_wr = 1'b1;
    tick();
    io_rd = 1'b0; io_wr = 1'b0;
    check("coll_old", dout_a, 16'h0005);
    rd(16'h1011);
    check("coll_new", dout_a, 16'h000A);
    check("dp_out", dp_a, 4'b0101);
    wr(16'h1011, 16'hFFF3);
    rd(16'h1011);
    check("dp_mask_a", dout_a, 16'h0003);
    check("dp_mask_b", dout_b, 16'h00F3);
    check("dp_out_mask", dp_a, 4'b1100);
    wr(16'h1011, 16'h0000);

    wr(16'h1005, 16'hFFFF);
    rd(16'h1005);
    check("unmapped_a", dout_a, 16'h0000);
    check("unmapped_b", dout_b, 16'h0000);
    rd(16'h1000);
    check("data_intact", dout_a, 16'h12AF);
    rd(16'h1001);
    check("no_word1_a", dout_a, 16'h0000);
    check("word1_b", dout_b, 16'h8888);

    wr(16'h1000, 16'h0000);
    wr(16'h1001, 16'h0000);
    wr(16'h1013, 16'h0002);
    tick();
    check("lzs_zero_b", seg_b, {{7{7'h7F}}, 7'b1000000});
    check("lzs_zero_a", seg_a, {{3{7'h7F}}, 7'b1000000});
    wr(16'h1000, 16'h0100);
    tick();
    check("lzs_mid_b", seg_b, {{5{7'h7F}}, 7'b1111001, 7'b1000000, 7'b1000000});
    check("lzs_mid_a", seg_a, {7'h7F, 7'b1111001, 7'b1000000, 7'b1000000});
    rd(16'h1013);
    check("ctrl_rd", dout_a, 16'h0002);
    wr(16'h1013, 16'hFFFF);
    rd(16'h1013);
    check("ctrl_mask", dout_a, 16'h0003);

    reset = 1'b1;
    tick();
    check("midrst_dout", dout_a, 16'h0000);
    check("midrst_seg", seg_a, {28{1'b1}});
    reset = 1'b0;
    wr(16'h1012, 16'h0001);
    wr(16'h1011, 16'h0001);
    wr(16'h1013, 16'h0001);
    for (int n = 4; n <= 27; n++) begin
      tick();
      dark = (((n - 1) % 16) >= 8);
      check("blink_seg", seg_a, dark ? 28'h000007F : 28'h0000000);
      check("blink_dp", dp_a, dark ? 4'hF : 4'hE);
    end

    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr(16'h1000, 16'h12AF);
    check("scan_an_1", an_a, 4'b1110);
    for (int n = 2; n <= 20; n++) begin
      tick();
      idx    = ((n - 1) / 4) % 4;
      exp_an = ~(4'b0001 << idx);
      check("scan_an", an_a, exp_an);
      check("scan_seg", sseg_a, pat[idx]);
      check("scan_dp", sdp_a, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
